// File: rtl/booth_pkg.sv
// Radix-4 Booth action-code definitions shared by the upstream encoder and booth_pp_accum.
package booth_pkg;

  localparam int unsigned BOOTH_W = 16;

  // Action-code bit positions: {ONE, TWO, NEG}
  localparam int unsigned ACT_ONE = 2;
  localparam int unsigned ACT_TWO = 1;
  localparam int unsigned ACT_NEG = 0;

  typedef logic [2:0] act_t;

  localparam act_t ACT_ZERO = 3'b000;
  localparam act_t ACT_P1   = 3'b100;
  localparam act_t ACT_P2   = 3'b010;
  localparam act_t ACT_M1   = 3'b101;
  localparam act_t ACT_M2   = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_pp_accum_if.sv
// Handshake bundle for booth_pp_accum; acc_in is present only when BOOTH_ACCUM_IN_EN is defined.
interface booth_pp_accum_if
  import booth_pkg::*;
#(
  parameter int unsigned W = BOOTH_W
);

  logic                  start;
  logic signed [W-1:0]   mcand;
  logic                  act_valid;
  act_t                  act;
  logic                  act_ready;
  logic                  prod_valid;
  logic signed [2*W-1:0] prod;
  logic                  prod_ready;
  logic                  busy;
  logic                  err;
`ifdef BOOTH_ACCUM_IN_EN
  logic signed [2*W-1:0] acc_in;

  modport master (
    output start, mcand, act_valid, act, prod_ready, acc_in,
    input  act_ready, prod_valid, prod, busy, err
  );

  modport slave (
    input  start, mcand, act_valid, act, prod_ready, acc_in,
    output act_ready, prod_valid, prod, busy, err
  );
`else
  modport master (
    output start, mcand, act_valid, act, prod_ready,
    input  act_ready, prod_valid, prod, busy, err
  );

  modport slave (
    input  start, mcand, act_valid, act, prod_ready,
    output act_ready, prod_valid, prod, busy, err
  );
`endif

endinterface

// File: rtl/booth_pp_gen.sv
// Combinational decode of one Booth action code into a (W+2)-bit signed partial product.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int unsigned W = BOOTH_W
) (
  input  logic signed [W-1:0] mcand,
  input  act_t                act,
  output logic signed [W+1:0] pp,
  output logic                illegal
);

  logic signed [W+1:0] m_s;
  logic signed [W+1:0] m2_s;
  logic signed [W+1:0] mag_s;

  // Select magnitude, then negate; two guard bits keep -2 * (-2^(W-1)) exact.
  always_comb begin
    m_s     = {{2{mcand[W-1]}}, mcand};
    m2_s    = m_s <<< 1;
    mag_s   = '0;
    illegal = 1'b0;
    case (act)
      ACT_ZERO:       mag_s = '0;
      ACT_P1, ACT_M1: mag_s = m_s;
      ACT_P2, ACT_M2: mag_s = m2_s;
      default: begin
        mag_s   = '0;
        illegal = 1'b1;
      end
    endcase
    if (act[ACT_NEG] && !illegal) begin
      pp = -mag_s;
    end else begin
      pp = mag_s;
    end
  end

endmodule

// File: rtl/booth_pp_accum.sv
// Radix-4 Booth partial-product accumulator: one action code per digit, LSB digit first.
// Build macro BOOTH_ACCUM_IN_EN seeds the accumulator from acc_in on an accepted start.
module booth_pp_accum
  import booth_pkg::*;
#(
  parameter int unsigned W = BOOTH_W
) (
  input logic             clk,
  input logic             rst_n,
  booth_pp_accum_if.slave bus
);

  localparam int unsigned D     = W / 2;
  localparam int unsigned CNT_W = (D > 1) ? $clog2(D) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                state_r;
  state_t                state_s;
  logic signed [W-1:0]   mcand_r;
  logic signed [2*W-1:0] acc_r;
  logic signed [2*W-1:0] acc_init_s;
  logic signed [2*W-1:0] pp_ext_s;
  logic signed [2*W-1:0] pp_shift_s;
  logic signed [W+1:0]   pp_s;
  logic [CNT_W-1:0]      cnt_r;
  logic                  err_r;
  logic                  act_ready_r;
  logic                  prod_valid_r;
  logic                  busy_r;
  logic                  accept_s;
  logic                  last_s;
  logic                  illegal_s;

  booth_pp_gen #(.W(W)) u_pp_gen (
    .mcand   (mcand_r),
    .act     (bus.act),
    .pp      (pp_s),
    .illegal (illegal_s)
  );

`ifdef BOOTH_ACCUM_IN_EN
  assign acc_init_s = bus.acc_in;
`else
  assign acc_init_s = '0;
`endif

  assign last_s     = (cnt_r == CNT_LAST);
  assign pp_ext_s   = {{(W-2){pp_s[W+1]}}, pp_s};
  assign pp_shift_s = pp_ext_s << {cnt_r, 1'b0};

  assign bus.act_ready  = act_ready_r;
  assign bus.prod_valid = prod_valid_r;
  assign bus.prod       = acc_r;
  assign bus.busy       = busy_r;
  assign bus.err        = err_r;

  // Next-state decode; a code is consumed only while running.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        accept_s = bus.act_valid;
        if (bus.act_valid && last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.prod_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register; handshake flags are decoded from the next state so they leave flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      act_ready_r  <= 1'b0;
      prod_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      act_ready_r  <= (state_s == ST_RUN);
      prod_valid_r <= (state_s == ST_DONE);
      busy_r       <= (state_s != ST_IDLE);
    end
  end

  // Operand capture on start and per-digit accumulation at weight 4^cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            mcand_r <= bus.mcand;
            acc_r   <= acc_init_s;
            cnt_r   <= '0;
            err_r   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            acc_r <= acc_r + pp_shift_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (illegal_s) begin
              err_r <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/booth_pp_accum.md
Name: booth_pp_accum

Overview:
- Consumer side of the radix-4 Booth action-code interface.
- Takes a signed multiplicand plus a stream of 3-bit Booth action codes, one per digit, LSB digit first, from the upstream encoder.
- Decodes each code into a partial product (0, ±M, ±2M) and accumulates it at weight 4^i, yielding a 2W-bit signed product.
- Serves as the sequential multiplier back-end in the FMAC datapath.

Parameters:
- W, 16, multiplicand/multiplier width in bits; must be even and >= 4. Digit count is D = W/2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; sampled only in IDLE
- mcand  in  W  signed multiplicand, captured on accepted start
- act_valid  in  1  action code valid
- act  in  3  Booth action code: bit2 = ONE, bit1 = TWO, bit0 = NEG
- act_ready  out  1  block accepts a code this cycle
- prod_valid  out  1  product available
- prod  out  2W  signed product
- prod_ready  in  1  downstream accepts product
- busy  out  1  high whenever the state is not IDLE
- err  out  1  sticky flag: an illegal action code was received

Behaviour:
- Reset values: all state cleared. FSM = IDLE, act_ready = 0, prod_valid = 0, prod = 0, busy = 0, err = 0, digit counter = 0, accumulator = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE
  - start = 1: capture mcand, clear the accumulator, counter and err, go to RUN next cycle.
  - start = 0: remain in IDLE.
- RUN
  - act_ready = 1.
  - On act_valid & act_ready: acc <= acc + (sext(pp) << 2*cnt) and cnt <= cnt + 1.
  - When the accept happens with cnt == D-1, go to DONE.
  - act_valid low: stall with no state change. Stalls are unbounded.
- DONE
  - prod_valid = 1 and prod = acc, both held stable until prod_ready.
  - On prod_valid & prod_ready, go to IDLE.
  - prod_ready may be tied high.
- start outside IDLE is ignored. The block does not queue starts.
- Partial-product decode:
  - Legal codes: 000 -> 0, 100 -> +M, 010 -> +2M, 011 -> -2M, 101 -> -M.
  - pp is computed at W+2 bits signed, so that -2 * (-2^(W-1)) is representable.
- Illegal codes (001, 110, 111):
  - Treated as pp = 0.
  - err is set the cycle after the accept and stays high until the next accepted start or reset.
  - The digit still counts toward D.
- Arithmetic: 2W-bit two's-complement accumulator. The true product always fits, so no saturation or overflow detection is needed.
- Latency:
  - start to act_ready high: 1 cycle.
  - Last accepted code to prod_valid: 1 cycle.
  - Minimum start-to-prod_valid: D+1 cycles.
  - Back-to-back operations: the next start is accepted in IDLE at the earliest, i.e. the cycle after the product handshake.
- Reset asserted mid-operation: immediate return to reset values. A partial result is never emitted.
- act_ready is 0 in IDLE and DONE. act_valid in those states is ignored and no code is consumed.

Optional Feature:
- Macro name: BOOTH_ACCUM_IN_EN.
- Defined:
  - Adds input port acc_in, width 2W, signed.
  - acc_in is captured on accepted start as the initial accumulator value, so prod = acc_in + mcand * multiplier, wrapping modulo 2^(2W).
- Undefined:
  - No acc_in port; the accumulator starts at 0.
- Timing and handshake are identical in both builds.

Decomposition:
- Package booth_pkg holds:
  - action-code bit positions (ACT_ONE = 2, ACT_TWO = 1, ACT_NEG = 0)
  - named legal codes (ACT_ZERO, ACT_P1, ACT_P2, ACT_M1, ACT_M2)
  - the FSM state enum
  - the shared width so the upstream encoder uses the same definitions
- Sub-module booth_pp_gen: combinational decode of (mcand, act) into a (W+2)-bit pp and an illegal flag. Instantiated once.

Test Plan (W = 16):
- Basic: mcand = 3, codes LSB-first 100, 100, then 6 x 000, act_valid held high -> prod_valid at cycle start+9, prod = 0x0000000F, err = 0.
- Sign: mcand = -7, codes 101, then 7 x 000 (multiplier 0xFFFF) -> prod = 0x00000007.
- Corner: mcand = 0x8000, codes 7 x 000, then 011 (multiplier 0x8000) -> prod = 0x40000000, no wrap.
- Handshake stress: random act_valid gaps of 0-5 cycles, prod_ready held low 10 cycles -> prod stable, no extra codes consumed, act_ready = 0 in DONE, start ignored while busy.
- Illegal code: 111 at digit 3 of the basic sequence -> prod = 0x0000000F, err = 1 until the next start, which clears it.
- Reset mid-RUN after 4 digits -> all outputs at reset values next cycle. A fresh start then yields a correct product. With BOOTH_ACCUM_IN_EN, basic case with acc_in = 100 -> prod = 115.
